// File: rtl/aes_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module      : aes_shift_rows_pipe
// Description : Pipelined AES ShiftRows / InvShiftRows unit carrying LANES
//               128-bit states per beat, with the direction selected per beat.
//               Valid/ready handshakes on both sides with full backpressure.
//               Bubbles collapse while the output is stalled.
// Parameters  : LANES  - 128-bit states per beat (1..4)
//               STAGES - register slots from input to output (1..4)
//               CNT_W  - width of the delivered-beat counter
// Ports       : clk, rst (synchronous, active-high)
//               in_valid/in_ready/in_inv/in_block  - upstream beat
//               in_key                             - round key (option only)
//               out_valid/out_ready/out_block      - downstream beat
//               out_count                          - beats delivered, wraps
// Options     : AES_SR_ADDKEY_EN - adds in_key; out_block becomes the
//               permuted state XOR in_key, applied in the final stage.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_shift_rows_pipe #(
    parameter int LANES  = 1,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [128*LANES-1:0]   in_block,
`ifdef AES_SR_ADDKEY_EN
    input  logic [128*LANES-1:0]   in_key,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [128*LANES-1:0]   out_block,
    output logic [CNT_W-1:0]       out_count
);

    localparam int c_W = 128 * LANES;

    logic [c_W-1:0]    w_perm;
    logic [STAGES-1:0] w_ld;
    logic [STAGES-1:0] w_src_v;
    logic [c_W-1:0]    w_src_d [STAGES];

    logic [STAGES-1:0] r_v;
    logic [c_W-1:0]    r_d [STAGES];
    logic [CNT_W-1:0]  r_count;

`ifdef AES_SR_ADDKEY_EN
    logic [c_W-1:0]    w_src_k [STAGES];
    logic [c_W-1:0]    r_k     [STAGES];
`endif

    // Byte (c,r) of a lane sits at bit 127-8*(4c+r). Forward takes the byte
    // r columns to the right, inverse r columns to the left; the "& 3" wraps
    // the column index (also for the negative inverse case).
    always_comb begin
        w_perm = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    w_perm[128*l + 127 - 8*(4*c + r) -: 8] =
                        in_block[128*l + 127 - 8*(4*((in_inv ? (c - r) : (c + r)) & 3) + r) -: 8];
                end
            end
        end
    end

    // Slot k may load when downstream drains this cycle or when any slot at
    // or after k is empty, because that hole lets the whole tail shift up.
    // Written in closed form so the enable chain is not self-referential.
    always_comb begin
        w_ld = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_ld[k] = out_ready;
            for (int j = 0; j < STAGES; j++) begin
                if (j >= k && !r_v[j]) begin
                    w_ld[k] = 1'b1;
                end
            end
        end
    end

    // Source of each slot: the input beat for slot 0, the previous slot after.
    always_comb begin
        w_src_v    = '0;
        w_src_v[0] = in_valid;
        w_src_d[0] = w_perm;
`ifdef AES_SR_ADDKEY_EN
        w_src_k[0] = in_key;
`endif
        for (int k = 1; k < STAGES; k++) begin
            w_src_v[k] = r_v[k-1];
            w_src_d[k] = r_d[k-1];
`ifdef AES_SR_ADDKEY_EN
            w_src_k[k] = r_k[k-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r_count <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_d[k] <= '0;
`ifdef AES_SR_ADDKEY_EN
                r_k[k] <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ld[k]) begin
                    r_v[k] <= w_src_v[k];
                    r_d[k] <= w_src_d[k];
`ifdef AES_SR_ADDKEY_EN
                    r_k[k] <= w_src_k[k];
`endif
                end
            end
            if (r_v[STAGES-1] && out_ready) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign in_ready  = w_ld[0];
    assign out_valid = r_v[STAGES-1];
    assign out_count = r_count;

    // The key rides along with its beat and is folded in after the last
    // register, so the option leaves the latency untouched.
`ifdef AES_SR_ADDKEY_EN
    assign out_block = r_v[STAGES-1] ? (r_d[STAGES-1] ^ r_k[STAGES-1]) : '0;
`else
    assign out_block = r_v[STAGES-1] ? r_d[STAGES-1] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_shift_rows_pipe
// Description : Self-checking bench for aes_shift_rows_pipe (LANES=4,
//               STAGES=3, CNT_W=4). A row-rotation reference model feeds a
//               scoreboard that is compared with the outputs every cycle;
//               directed FIPS-197 vectors pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_shift_rows_pipe;

    localparam int LANES  = 4;
    localparam int STAGES = 3;
    localparam int CNT_W  = 4;
    localparam int W      = 128 * LANES;

    localparam logic [127:0] c_T1 = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] c_E1 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] c_AK = 128'h2b40a2cf1f4bad5147beee0ee1d8671a;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_inv;
    logic [W-1:0]     in_block;
    logic [W-1:0]     in_key;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_block;
    logic [CNT_W-1:0] out_count;

    int n_tests = 0;
    int n_fail  = 0;

    aes_shift_rows_pipe #(
        .LANES  (LANES),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_block  (in_block),
`ifdef AES_SR_ADDKEY_EN
        .in_key    (in_key),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: each row is a list of four bytes rotated r places,
    // left for ShiftRows, right for InvShiftRows.
    function automatic logic [W-1:0] model(input logic [W-1:0] blk, input logic inv);
        logic [W-1:0] o;
        logic [7:0]   row [4];
        logic [7:0]   t;
        o = blk;
        for (int l = 0; l < LANES; l++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) row[c] = blk[128*l + 127 - 8*(4*c + r) -: 8];
                for (int n = 0; n < r; n++) begin
                    if (!inv) begin
                        t = row[0]; row[0] = row[1]; row[1] = row[2]; row[2] = row[3]; row[3] = t;
                    end else begin
                        t = row[3]; row[3] = row[2]; row[2] = row[1]; row[1] = row[0]; row[0] = t;
                    end
                end
                for (int c = 0; c < 4; c++) o[128*l + 127 - 8*(4*c + r) -: 8] = row[c];
            end
        end
        return o;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    typedef struct {
        logic [W-1:0] data;
        int           acc;
    } beat_t;

    beat_t q[$];
    int    cyc  = 0;
    int    mcnt = 0;

    always @(negedge clk) begin
        logic         exp_ov;
        logic [W-1:0] exp_d;
        cyc++;
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            exp_ov = (q.size() > 0) && (cyc - q[0].acc >= STAGES);
            chk("out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, exp_ov});
            if (out_valid && q.size() > 0) chk("out_block", out_block, q[0].data);
            if (!out_valid) chk("out_block_idle", out_block, '0);
            chk("in_ready", {{(W-1){1'b0}}, in_ready},
                {{(W-1){1'b0}}, !(q.size() == STAGES && !out_ready)});
            chk("out_count", {{(W-CNT_W){1'b0}}, out_count}, W'(mcnt));
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                mcnt = (mcnt + 1) % (1 << CNT_W);
            end
            if (in_valid && in_ready) begin
                exp_d = model(in_block, in_inv);
`ifdef AES_SR_ADDKEY_EN
                exp_d = exp_d ^ in_key;
`endif
                q.push_back('{data: exp_d, acc: cyc});
            end
        end
    end

    // ---------------- driver ----------------
    bit fired;
    bit ir_s;

    task automatic step();
        @(negedge clk);
        #1;
        fired = in_valid && in_ready;
        ir_s  = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        for (int i = 0; i < W / 32; i++) begin
            in_block[32*i +: 32] = $urandom;
            in_key[32*i +: 32]   = $urandom;
        end
        in_inv = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (STAGES + 4) step();
    endtask

    task automatic wait_lane0(input string nm, input logic [127:0] exp);
        int n = 0;
        bit got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            #1;
            if (out_valid) got = 1;
            else n++;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no out_valid expected a beat within 20 cycles", nm);
        end else begin
            chk(nm, {{(W-128){1'b0}}, out_block[127:0]}, {{(W-128){1'b0}}, exp});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] tmp;
        int sent;
        int k;
        bit saw_low;

        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b1;
        in_block = '0; in_key = '0;
        repeat (3) step();
        rst = 1'b0;

        // Pin the model against the published vectors.
        tmp = model({4{c_T1}}, 1'b0);
        chk("pin_fwd", {{(W-128){1'b0}}, tmp[127:0]}, {{(W-128){1'b0}}, c_E1});
        tmp = model({4{c_E1}}, 1'b1);
        chk("pin_inv", {{(W-128){1'b0}}, tmp[127:0]}, {{(W-128){1'b0}}, c_T1});

        // Backpressure: 10 beats, out_ready low for cycles 3..8.
        do_reset();
        sent = 0; k = 0; saw_low = 0;
        rand_beat();
        in_valid = 1'b1;
        while (sent < 10 && k < 60) begin
            out_ready = !(k >= 3 && k <= 8);
            step();
            if (!ir_s) saw_low = 1;
            if (fired) begin
                sent++;
                rand_beat();
            end
            in_valid = (sent < 10);
            k++;
        end
        drain();
        chk("bp_in_ready_fell", {{(W-1){1'b0}}, saw_low}, {{(W-1){1'b0}}, 1'b1});
        chk("bp_count", {{(W-CNT_W){1'b0}}, out_count}, W'(10));

        // Forward then inverse FIPS-197 vectors, lanes 1..3 random.
        rand_beat();
        in_block[127:0] = c_T1; in_inv = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_lane0("t1_fwd", c_E1);
        rand_beat();
        in_block[127:0] = c_E1; in_inv = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_lane0("t2_inv", c_T1);

`ifdef AES_SR_ADDKEY_EN
        rand_beat();
        in_block[127:0] = c_T1; in_inv = 1'b0; in_key = '1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_lane0("t6_addkey", c_AK);
`endif

        // Alternating fwd/inv beats back to back.
        for (int i = 0; i < 6; i++) begin
            rand_beat();
            in_block[127:0] = i[0] ? c_E1 : c_T1;
            in_inv   = i[0];
            in_valid = 1'b1;
            step();
        end
        drain();

        // Lane pattern: lane L bytes L, L+1, ... from the first byte.
        for (int l = 0; l < LANES; l++)
            for (int i = 0; i < 16; i++)
                in_block[128*l + 127 - 8*i -: 8] = 8'(l + i);
        in_inv = 1'b0; in_valid = 1'b1;
        step();
        in_inv = 1'b1;
        step();
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_beat(); step();
        rand_beat(); step();
        rand_beat();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", {{(W-1){1'b0}}, out_valid}, '0);
        chk("rst_out_count", {{(W-CNT_W){1'b0}}, out_count}, '0);
        chk("rst_in_ready", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, 1'b1});
        chk("rst_out_block", out_block, '0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rand_beat(); in_valid = 1'b1;
        step();
        drain();

        // Counter wrap: 17 deliveries on a 4-bit counter.
        do_reset();
        sent = 0; k = 0;
        rand_beat(); in_valid = 1'b1; out_ready = 1'b1;
        while (sent < 17 && k < 100) begin
            step();
            if (fired) begin
                sent++;
                rand_beat();
            end
            in_valid = (sent < 17);
            k++;
        end
        drain();
        chk("wrap_count", {{(W-CNT_W){1'b0}}, out_count}, W'(1));

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if (!in_valid || fired) rand_beat();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
